// File: rtl/row_col_dram_ctrl.sv
// row_col_dram_ctrl: open-page request controller for the row/column DRAM array.
// Serialises single-beat requests into ACT/RD/WR/PRE/REF commands with fixed spacing.
`timescale 1ns/1ps
module row_col_dram_ctrl #(
  parameter int unsigned ROW_W  = 4,
  parameter int unsigned COL_W  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned T_RP   = 2,
  parameter int unsigned T_RCD  = 2,
  parameter int unsigned CL     = 2,
  parameter int unsigned T_REFI = 64,
  parameter int unsigned T_RFC  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ROW_W+COL_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic [2:0]               mem_cmd,
  output logic [ROW_W-1:0]         mem_row,
  output logic [COL_W-1:0]         mem_col,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned REF_W  = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  // Wait-state reload values: the command state itself accounts for one cycle.
  localparam int unsigned RP_LD  = (T_RP  > 1) ? T_RP  - 2 : 0;
  localparam int unsigned RCD_LD = (T_RCD > 1) ? T_RCD - 2 : 0;
  localparam int unsigned RFC_LD = (T_RFC > 1) ? T_RFC - 2 : 0;
  localparam int unsigned CL_LD  = (CL    > 1) ? CL    - 1 : 0;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b001;
  localparam logic [2:0] CMD_RD  = 3'b010;
  localparam logic [2:0] CMD_WR  = 3'b011;
  localparam logic [2:0] CMD_PRE = 3'b100;
  localparam logic [2:0] CMD_REF = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT,
    S_ACCESS, S_RD_WAIT, S_REF, S_REF_WAIT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [REF_W-1:0]   r_ref_cnt;
  logic               r_ref_pending;
  logic               r_for_ref;
  logic               r_row_open;
  logic [ROW_W-1:0]   r_open_row;
  logic               r_req_write;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [DATA_W-1:0]  r_req_wdata;
  logic [2:0]         r_cmd, w_cmd_nxt;
  logic               r_resp_valid, w_resp_nxt;
  logic [DATA_W-1:0]  r_resp_rdata;
  logic               w_hs;
  logic               w_write_nxt;
  logic [ROW_W-1:0]   w_req_row;
  logic [ROW_W-1:0]   w_row_nxt;

  assign w_req_row   = req_addr[ADDR_W-1:COL_W];
  assign req_ready   = (r_state == S_IDLE) && !r_ref_pending;
  assign w_write_nxt = w_hs ? req_write : r_req_write;
  assign w_row_nxt   = w_hs ? w_req_row : r_req_addr[ADDR_W-1:COL_W];

  assign mem_cmd    = r_cmd;
  assign mem_row    = r_req_addr[ADDR_W-1:COL_W];
  assign mem_col    = r_req_addr[COL_W-1:0];
  assign mem_wdata  = r_req_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

  // Next-state, wait counter, command and response decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    w_hs        = 1'b0;
    w_resp_nxt  = 1'b0;
    w_cmd_nxt   = CMD_NOP;
    case (r_state)
      S_IDLE: begin
        if (r_ref_pending) begin
          w_state_nxt = r_row_open ? S_PRE : S_REF;
        end else if (req_valid) begin
          w_hs = 1'b1;
          if (r_row_open && (w_req_row == r_open_row)) w_state_nxt = S_ACCESS;
          else if (r_row_open)                         w_state_nxt = S_PRE;
          else                                         w_state_nxt = S_ACT;
        end
      end
      S_PRE: begin
        if (T_RP > 1) begin
          w_state_nxt = S_PRE_WAIT;
          w_cnt_nxt   = CNT_W'(RP_LD);
        end else begin
          w_state_nxt = r_for_ref ? S_REF : S_ACT;
        end
      end
      S_PRE_WAIT: if (r_cnt == '0) w_state_nxt = r_for_ref ? S_REF : S_ACT;
      S_ACT: begin
        if (T_RCD > 1) begin
          w_state_nxt = S_ACT_WAIT;
          w_cnt_nxt   = CNT_W'(RCD_LD);
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACT_WAIT: if (r_cnt == '0) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (r_req_write) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RD_WAIT;
          w_cnt_nxt   = CNT_W'(CL_LD);
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_resp_nxt  = 1'b1;
        end
      end
      S_REF: begin
        if (T_RFC > 1) begin
          w_state_nxt = S_REF_WAIT;
          w_cnt_nxt   = CNT_W'(RFC_LD);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REF_WAIT: if (r_cnt == '0) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    // Command is registered so it appears in the cycle its state is occupied.
    case (w_state_nxt)
      S_PRE:    w_cmd_nxt = CMD_PRE;
      S_ACT:    w_cmd_nxt = CMD_ACT;
      S_ACCESS: w_cmd_nxt = w_write_nxt ? CMD_WR : CMD_RD;
      S_REF:    w_cmd_nxt = CMD_REF;
      default:  w_cmd_nxt = CMD_NOP;
    endcase
  end

  // State, counters, open-row tracking, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
      r_for_ref     <= 1'b0;
      r_row_open    <= 1'b0;
      r_open_row    <= '0;
      r_req_write   <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_cmd         <= CMD_NOP;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cmd        <= w_cmd_nxt;
      r_resp_valid <= w_resp_nxt;
      if (w_resp_nxt) r_resp_rdata <= mem_rdata;
      if (r_state == S_IDLE) r_for_ref <= r_ref_pending;
      if (w_hs) begin
        r_req_write <= req_write;
        r_req_addr  <= req_addr;
        r_req_wdata <= req_wdata;
      end
      if (w_state_nxt == S_ACT) begin
        r_row_open <= 1'b1;
        r_open_row <= w_row_nxt;
      end else if ((w_state_nxt == S_PRE) || (w_state_nxt == S_REF)) begin
        r_row_open <= 1'b0;
      end
      // A new interval expiring outranks the clear from a REF issued in the same cycle.
      if (r_ref_cnt == REF_W'(T_REFI - 1)) begin
        r_ref_cnt     <= '0;
        r_ref_pending <= 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + REF_W'(1);
        if ((w_state_nxt == S_REF) && (r_state != S_REF)) r_ref_pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/row_col_dram_ctrl.md
# row_col_dram_ctrl

Request-side controller that drives the 16×16 row/column DRAM array model with explicit ACT / RD / WR / PRE / REF commands. It accepts single-beat read/write requests with an 8-bit flat address {row, col}, keeps one row open (open-page policy), enforces tRP / tRCD / CL / tRFC spacing, and inserts periodic refresh. It sits between a simple valid/ready master and the array's command port.

## Interface
- ROW_W, 4, row address bits (req_addr[7:4])
- COL_W, 4, column address bits (req_addr[3:0])
- DATA_W, 8, data width
- T_RP, 2, cycles from PRE to the next ACT/REF (≥1)
- T_RCD, 2, cycles from ACT to RD/WR (≥1)
- CL, 2, cycles from RD to mem_rdata valid (≥1)
- T_REFI, 64, refresh interval in cycles
- T_RFC, 4, cycles from REF to the next command (≥1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ROW_W+COL_W  {row, col}
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle pulse, read data valid
- resp_rdata  out  DATA_W  read data
- mem_cmd  out  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF
- mem_row  out  ROW_W  row for ACT
- mem_col  out  COL_W  column for RD/WR
- mem_wdata  out  DATA_W  write data, valid in WR cycle
- mem_rdata  in  DATA_W  array read data

## Operation
- States: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, ACCESS, RD_WAIT, REF, REF_WAIT.
- Tracked: row_open (1 bit), open_row (ROW_W), latched request (write, addr, wdata).
- req_ready = (state==IDLE) && !ref_pending, derived from registers only.
- On handshake in IDLE, latch request, then: row hit (row_open && row match) -> ACCESS; row_open && miss -> PRE; !row_open -> ACT.
- PRE: issue PRE, clear row_open; wait so next ACT/REF is T_RP cycles after PRE.
- ACT: issue ACT with mem_row; set row_open, open_row; RD/WR issued T_RCD cycles after ACT.
- ACCESS: issue RD or WR with mem_col (and mem_wdata for WR). WR -> IDLE next cycle. RD -> RD_WAIT.
- RD_WAIT: capture mem_rdata at the edge ending cycle RD+CL; resp_valid high in cycle RD+CL+1, state IDLE in that same cycle.
- Refresh: free-running counter, reload every T_REFI cycles, sets ref_pending (sticky). Serviced only from IDLE: PRE first if row_open (+T_RP), then REF, then T_RFC-cycle wait; ref_pending cleared on REF issue; row closed afterwards.
- All non-command cycles drive NOP. mem_row/mem_col/mem_wdata hold last latched value.

## Timing
- Reset values: mem_cmd NOP, mem_row 0, mem_col 0, mem_wdata 0, resp_valid 0, resp_rdata 0, row_open 0, refresh counter 0, ref_pending 0, state IDLE (req_ready 1).
- Defaults, handshake in cycle 0:
  - Read hit: RD c1, resp_valid c4.
  - Read closed row: ACT c1, RD c3, resp_valid c6.
  - Read miss: PRE c1, ACT c3, RD c5, resp_valid c8.
  - Write hit: WR c1, req_ready high c2.
- Back-to-back: a new request may handshake in the cycle resp_valid is high (or cycle after WR).
- ref_pending rising while a request is in flight: finish that request, then refresh before next handshake.
- ref_pending and req_valid both true in IDLE: refresh wins, req_ready 0.
- Address wrap: no sequencing across rows; each request independent.
- Reset mid-operation: abort immediately, all outputs to reset values, no resp_valid for the aborted read, open row forgotten.

## Test plan
- Write all 256 addresses with data row+col, then read all -> every resp_rdata == row+col, one resp_valid per read.
- Write 0x35 to 0x3A, read 0x3A -> RD on cycle 1 after handshake (row hit), resp_valid exactly 3 cycles after RD, data 0x35.
- Open row 2, read 0x71 -> PRE, NOP, ACT row 7, NOP, RD col 1; resp_valid 8 cycles after handshake.
- Run idle 64 cycles with row 5 open -> PRE, then REF 2 cycles later, req_ready low until T_RFC done; next read of row 5 issues ACT.
- Hold req_valid across refresh trigger -> req_ready stays 0 during refresh; request accepted afterwards and completes correctly.
- Assert rst_n low during RD_WAIT -> mem_cmd NOP, resp_valid never pulses, next read issues ACT (row closed).
